uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver for the host link: samples the host-driven serial line (host tx pin), recovers 8N1 bytes.
//  Presents each byte on a valid/ready interface toward the core's CSR/GPIO side.
//  Counterpart of the existing transmit path that drives the host rx pin.
//  Sits between the board top-level pin and the core; one clock domain (core clk from the clock wizard).
// PARAMETERS
//  CLK_FREQ  20_000_000  core clock frequency in Hz
//  BAUD      115_200     line rate in bit/s
//  OVS       16          oversampling ticks per bit (power of 2, >= 8)
// PORTS
//  clk          in   1  core clock; all logic on posedge
//  reset        in   1  synchronous, active-low reset
//  rx_i         in   1  asynchronous serial input, idle high
//  data_o       out  8  received byte, stable while valid_o=1
//  valid_o      out  1  byte available
//  ready_i      in   1  consumer accepts; transfer when valid_o & ready_i
//  frame_err_o  out  1  1-cycle pulse: stop bit sampled low
//  overrun_o    out  1  1-cycle pulse: byte completed while buffer full, new byte dropped
//  parity_err_o out  1  1-cycle pulse: parity mismatch (constant 0 when UART_RX_PARITY_EN undefined)
// BEHAVIOUR
//  - Reset (reset=0 at posedge): state IDLE, tick/bit counters 0, data_o=8'h00, valid_o=0, all pulses 0; sync regs=1.
//  - Reset mid-frame aborts the frame; no byte, no error pulse.
//  - rx_i passes a 2-flop synchronizer (reset value 1); FSM sees rx_s, 2-cycle latency.
//  - Tick: DIV = round(CLK_FREQ/(BAUD*OVS)) (defaults: 11); 1-cycle tick every DIV clocks; divider cleared on IDLE->START.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; error exit via BREAK.
//  - IDLE: rx_s==0 -> START, tick count 0.
//  - START: at tick OVS/2-1 sample rx_s; 1 -> IDLE (glitch, no pulse); 0 -> DATA, tick count 0.
//  - DATA: sample every OVS ticks (mid-bit); shift in LSB first; after bit 7 -> PARITY or STOP.
//  - STOP: sample after OVS ticks.
//    - 1: byte complete -> IDLE.
//    - 0: frame_err_o pulse, byte discarded -> BREAK.
//  - BREAK: wait until rx_s==1, then IDLE (a held-low line reports exactly one framing error).
//  - Byte complete:
//    - buffer empty, or buffer full with ready_i=1 this cycle: load data_o, valid_o=1 next cycle.
//    - buffer full and ready_i=0: overrun_o pulse, old byte kept.
//  - valid_o clears on cycle after valid_o&ready_i unless a new byte loads that same cycle.
//  - Latency: valid_o rises 1 clk after the stop-bit sample tick.
//  - Counter widths: $clog2(DIV), $clog2(OVS), 3-bit bit index; all wrap-free by construction.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY state after bit 7 samples one even-parity bit (mid-bit, OVS ticks).
//    - Mismatch: parity_err_o pulse at STOP-sample cycle, byte discarded, FSM proceeds to STOP check.
//    - Framing error takes precedence (only frame_err_o pulses).
//  UART_RX_PARITY_EN undefined: no PARITY state, 8N1 frame, parity_err_o tied 0.
// STRUCTURE
//  uart_pkg:
//    - typedef enum logic [2:0] uart_rx_state_t {IDLE,START,DATA,PARITY,STOP,BREAK}
//    - localparam UART_DATA_W=8
//    - function baud_div(clk_freq,baud,ovs)
//  Sub-module uart_baud_tick (params DIV; ports clk, reset, clear_i, tick_o).
//    - Shared with the transmitter using OVS=1.
//  uart_rx owns synchronizer, FSM, shift register, output buffer.
// TESTING (defaults, bit period = 176 clk)
//  - Send 8'hA5 8N1, ready_i=1 -> one valid_o pulse, data_o=8'hA5, no error pulses.
//  - Send 8'h3C then 8'hC3 back-to-back, ready_i=0 -> data_o=8'h3C held, overrun_o pulse once, valid_o stays 1.
//  - Send 8'h55 with stop bit 0, then line held low 2000 clk -> one frame_err_o, no valid_o; next byte 8'h01 received OK.
//  - 40-clk low glitch on idle line -> FSM back to IDLE, no valid_o, no error.
//  - reset=0 mid bit 4 of 8'hFF, release, send 8'h12 -> only 8'h12 delivered, valid_o=0 during reset.
//  - UART_RX_PARITY_EN: 8'h07 with parity bit 0 (wrong) -> parity_err_o pulse, no valid_o; with 1 -> data_o=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the host-link UART (receive and transmit paths).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
    int den;
    den = baud * ovs;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// One-cycle tick every DIV clocks; clear_i restarts the period from zero.
// Latency: first tick DIV cycles after clear; never stalls.
module uart_baud_tick #(
  parameter int DIV = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST) && !clear_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) with a one-byte output buffer.
// valid_o rises 1 clk after the stop-bit sample; a byte finishing while the buffer is held full is dropped (overrun_o).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 20_000_000,
  parameter int BAUD     = 115_200,
  parameter int OVS      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   parity_err_o
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVS);
  localparam int TW  = $clog2(OVS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);

  uart_rx_state_t state_q, state_d;

  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad_q, parity_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic rx_s;
  logic tick;
  logic samp;
  logic baud_clr;
  logic byte_done;

  assign rx_meta_d = rx_i;
  assign rx_sync_d = rx_meta_q;
  assign rx_s      = rx_sync_q;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .clear_i(baud_clr),
    .tick_o (tick)
  );

  // START samples at mid start bit; every later sample is one full bit on.
  assign samp = tick && (tick_cnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (samp) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (samp && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (samp) state_d = STOP;
      STOP:   if (samp) state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_clr    = 1'b0;
    byte_done   = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready_i;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        baud_clr   = !rx_s;
      end
      START: begin
        if (samp) tick_cnt_d = '0;
      end
      DATA: begin
        if (samp) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s, shift_q[UART_DATA_W-1:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (samp) begin
          tick_cnt_d   = '0;
          parity_bad_d = (rx_s != ^shift_q);
        end
      end
`endif
      STOP: begin
        // A low stop bit wins over a parity mismatch.
        if (samp) begin
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (parity_bad_q) begin
            parity_err_d = 1'b1;
          end
`endif
          else begin
            byte_done = 1'b1;
          end
        end
      end
      BREAK: begin
        tick_cnt_d = '0;
      end
      default: begin
        tick_cnt_d = '0;
      end
    endcase

    if (byte_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of single frames plus hand sequences for overrun, break, glitch, reset and parity.
module tb_uart_rx;

  localparam int BIT_CLK = 176;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + 11 * (8 + 16 * 10);
`else
  localparam int LAT = 3 + 11 * (8 + 16 * 9);
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int n_acc = 0, n_frame = 0, n_ovr = 0, n_par = 0;
  int start_cyc = 0;
  int last_rise = -1;
  logic valid_prev = 1'b0;
  logic par_flip = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_frame;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_o && !valid_prev) last_rise = cyc;
      if (valid_o && ready_i) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got byte 0x%0h, expected none", data_o);
        end else begin
          check("sb_data", int'(data_o), int'(exp_q.pop_front()));
        end
      end
      if (frame_err_o)  n_frame++;
      if (overrun_o)    n_ovr++;
      if (parity_err_o) n_par++;
    end
    valid_prev = valid_o;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected end before 80000", cyc);
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a0, f0, o0, p0;
  task automatic snap();
    a0 = n_acc; f0 = n_frame; o0 = n_ovr; p0 = n_par;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 0};
    vecs[5] = '{8'h3C, 1'b0, 0, 1};
    vecs[6] = '{8'h6E, 1'b1, 1, 0};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_frame", int'(frame_err_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_parity", int'(parity_err_o), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(50);

    // Single frames, consumer always ready
    for (int i = 0; i < 7; i++) begin
      snap();
      if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].data);
      send_byte(vecs[i].data, vecs[i].stop);
      idle(300);
      check("vec_acc", n_acc - a0, vecs[i].exp_acc);
      check("vec_frame", n_frame - f0, vecs[i].exp_frame);
      check("vec_overrun", n_ovr - o0, 0);
      if (vecs[i].exp_acc != 0) check("vec_latency", last_rise - start_cyc, LAT);
    end

    // Back-to-back bytes into a stalled consumer
    snap();
    ready_i = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(300);
    @(negedge clk);
    check("ovr_valid_held", int'(valid_o), 1);
    check("ovr_data_held", int'(data_o), 8'h3C);
    check("ovr_pulses", n_ovr - o0, 1);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ovr_valid_clear", int'(valid_o), 0);
    check("ovr_acc", n_acc - a0, 1);

    // Framing error followed by a held-low line
    snap();
    send_byte(8'h55, 1'b0);
    repeat (2000) @(posedge clk);
    #1;
    idle(300);
    check("brk_frame", n_frame - f0, 1);
    check("brk_acc", n_acc - a0, 0);
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1);
    idle(300);
    check("brk_next_acc", n_acc - a0, 1);
    check("brk_next_frame", n_frame - f0, 1);

    // Short low glitch on an idle line
    snap();
    rx_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(400);
    check("glitch_acc", n_acc - a0, 0);
    check("glitch_frame", n_frame - f0, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle(300);
    check("glitch_next_acc", n_acc - a0, 1);
    check("glitch_next_lat", last_rise - start_cyc, LAT);

    // Reset in the middle of bit 4 of 8'hFF
    send_bit(1'b0);
    rx_i = 1'b1;
    repeat (4 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_data", int'(data_o), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1500);
    snap();
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    idle(300);
    check("midrst_acc", n_acc - a0, 1);
    check("midrst_frame", n_frame - f0, 0);
    check("midrst_overrun", n_ovr - o0, 0);

`ifdef UART_RX_PARITY_EN
    snap();
    par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    idle(300);
    par_flip = 1'b0;
    check("par_bad_pulse", n_par - p0, 1);
    check("par_bad_acc", n_acc - a0, 0);
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    idle(300);
    check("par_ok_acc", n_acc - a0, 1);
    check("par_ok_pulse", n_par - p0, 1);
`else
    check("parity_tied_low", n_par, 0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
